mm_run_sequencer: RTL and testbench
===================================

// Module: mm_run_sequencer
// PURPOSE
//   Sequences the Montgomery multiplier core for batch operation. Accepts a command
//   "run N multiplications", then issues N back-to-back start pulses to the core, one per
//   completed done. Counts completions and elapsed cycles for the processor, and enforces a
//   per-run watchdog. Sits between processor-side control registers and the core's start/done.
// PARAMETERS
//   RUN_WIDTH   16    width of run count and completion counter
//   CYCLE_WIDTH 32    width of elapsed-cycle counter (saturating)
//   TIMEOUT     4096  max cycles WAIT may last per run; 0 disables watchdog
// PORTS
//   clock_i       in   1            single clock, rising edge
//   reset_i       in   1            asynchronous, active-low reset
//   cmd_valid_i   in   1            command valid
//   cmd_ready_o   out  1            high in IDLE only
//   cmd_runs_i    in   RUN_WIDTH    number of multiplications requested
//   abort_i       in   1            abandon batch (level, sampled each cycle)
//   mm_start_o    out  1            one-cycle start pulse to core
//   mm_done_i     in   1            core completion pulse
//   busy_o        out  1            high in START/WAIT/GAP
//   done_o        out  1            one-cycle pulse, batch completed
//   error_o       out  1            sticky watchdog flag
//   runs_done_o   out  RUN_WIDTH    completions in current/last batch
//   cycles_o      out  CYCLE_WIDTH  busy cycles in current/last batch
// BEHAVIOUR
//   Reset (reset_i low, async): state=IDLE; cmd_ready_o=1 after release; all other outputs 0.
//   States: IDLE, START, WAIT, GAP, DONE, ERROR. All outputs registered or state-decoded.
//   IDLE: cmd_ready_o=1. Accept on cmd_valid_i&cmd_ready_o at edge k: clear runs_done_o,
//     cycles_o, error_o; latch remaining=cmd_runs_i.
//     cmd_runs_i==0 -> DONE (done_o high cycle k+1, no start issued). Else -> START.
//   START: mm_start_o=1 for exactly this cycle; watchdog cleared; -> WAIT.
//   WAIT: on mm_done_i: runs_done_o+1, remaining-1; remaining hits 0 -> DONE, else -> GAP.
//     watchdog increments each WAIT cycle; reaching TIMEOUT without done -> ERROR.
//   GAP: one idle cycle so core sees start after done deasserts -> START.
//     Done at cycle d -> next mm_start_o at d+2; last done at d -> done_o at d+1.
//   DONE: done_o=1 one cycle -> IDLE. ERROR: error_o set (sticky until next accept),
//     no done_o -> IDLE.
//   cycles_o: +1 every cycle in START/WAIT/GAP; saturates at all-ones, never wraps.
//   runs_done_o/cycles_o hold after batch until next accepted command.
//   Boundaries:
//     abort_i in START/WAIT/GAP -> IDLE next edge, no done_o, error_o unchanged.
//     abort_i in IDLE/DONE ignored.
//     abort_i with mm_done_i same cycle -> abort wins; completion not counted.
//     mm_done_i with watchdog expiry same cycle -> done wins.
//     mm_done_i outside WAIT ignored (not counted).
//     cmd_valid_i outside IDLE ignored (ready low, no queueing).
//     cmd_runs_i = all-ones handled; counters never overflow (runs_done_o <= cmd_runs_i).
//     reset mid-batch: immediate IDLE, mm_start_o drops asynchronously, counters cleared.
// TESTING
//   1 runs=3, core model done 50 cyc after start -> 3 start pulses spaced 52 cyc,
//     done_o once, runs_done_o=3, cycles_o=3*51+2=155.
//   2 runs=0 -> done_o at k+1, mm_start_o never high, runs_done_o=0, cycles_o=0.
//   3 TIMEOUT=16, core never responds -> error_o high after 16 WAIT cycles,
//     no done_o, cmd_ready_o=1; next command clears error_o.
//   4 runs=5, abort_i at 2nd run's done cycle -> IDLE, runs_done_o=1, no done_o, no further starts.
//   5 CYCLE_WIDTH=4, runs=2 with 20-cyc core -> cycles_o saturates at 15;
//     spurious mm_done_i in IDLE/GAP ignored.
//   6 reset_i low mid-WAIT (async, off clock edge) -> outputs 0 immediately;
//     after release cmd_ready_o=1 and new batch runs normally.

Source files
------------

// File: rtl/mm_run_sequencer_if.sv
// Command/status and core start/done bundle for mm_run_sequencer.
// The slave modport is the sequencer side; the master modport is the processor/core side.
interface mm_run_sequencer_if #(
  parameter int RUN_WIDTH   = 16,
  parameter int CYCLE_WIDTH = 32
);
  logic                   cmd_valid_i;
  logic                   cmd_ready_o;
  logic [RUN_WIDTH-1:0]   cmd_runs_i;
  logic                   abort_i;
  logic                   mm_start_o;
  logic                   mm_done_i;
  logic                   busy_o;
  logic                   done_o;
  logic                   error_o;
  logic [RUN_WIDTH-1:0]   runs_done_o;
  logic [CYCLE_WIDTH-1:0] cycles_o;

  modport slave (
    input  cmd_valid_i, cmd_runs_i, abort_i, mm_done_i,
    output cmd_ready_o, mm_start_o, busy_o, done_o, error_o, runs_done_o, cycles_o
  );

  modport master (
    output cmd_valid_i, cmd_runs_i, abort_i, mm_done_i,
    input  cmd_ready_o, mm_start_o, busy_o, done_o, error_o, runs_done_o, cycles_o
  );
endinterface

// File: rtl/mm_run_sequencer.sv
// Batch sequencer for the Montgomery multiplier: issues one start per completion,
// counts completions and busy cycles, and guards each run with a watchdog.
module mm_run_sequencer #(
  parameter int RUN_WIDTH   = 16,
  parameter int CYCLE_WIDTH = 32,
  parameter int TIMEOUT     = 4096
) (
  input  logic              clock_i,
  input  logic              reset_i,
  mm_run_sequencer_if.slave bus
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT, S_GAP, S_DONE, S_ERROR
  } state_e;

  state_e                 state_q, state_d;
  logic [RUN_WIDTH-1:0]   remaining_q, remaining_d;
  logic [RUN_WIDTH-1:0]   runs_done_q, runs_done_d;
  logic [CYCLE_WIDTH-1:0] cycles_q, cycles_d;
  logic [WD_W-1:0]        wdog_q, wdog_d;
  logic                   error_q, error_d;
  logic                   busy;

  assign busy = (state_q == S_START) || (state_q == S_WAIT) || (state_q == S_GAP);

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      runs_done_q <= '0;
      cycles_q    <= '0;
      wdog_q      <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      runs_done_q <= runs_done_d;
      cycles_q    <= cycles_d;
      wdog_q      <= wdog_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    runs_done_d = runs_done_q;
    cycles_d    = cycles_q;
    wdog_d      = wdog_q;
    error_d     = error_q;

    if (busy && (cycles_q != '1)) cycles_d = cycles_q + CYCLE_WIDTH'(1);

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid_i) begin
          runs_done_d = '0;
          cycles_d    = '0;
          error_d     = 1'b0;
          remaining_d = bus.cmd_runs_i;
          state_d     = (bus.cmd_runs_i == '0) ? S_DONE : S_START;
        end
      end
      S_START: begin
        wdog_d  = '0;
        state_d = bus.abort_i ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        // Priority: abort, then completion, then watchdog expiry.
        if (bus.abort_i) begin
          state_d = S_IDLE;
        end else if (bus.mm_done_i) begin
          runs_done_d = runs_done_q + RUN_WIDTH'(1);
          remaining_d = remaining_q - RUN_WIDTH'(1);
          state_d     = (remaining_q == RUN_WIDTH'(1)) ? S_DONE : S_GAP;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
          if ((TIMEOUT != 0) && (wdog_q == WD_LAST)) begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end
        end
      end
      // One quiet cycle so the core sees start only after its done has dropped.
      S_GAP:   state_d = bus.abort_i ? S_IDLE : S_START;
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.cmd_ready_o = (state_q == S_IDLE);
  assign bus.mm_start_o  = (state_q == S_START);
  assign bus.busy_o      = busy;
  assign bus.done_o      = (state_q == S_DONE);
  assign bus.error_o     = error_q;
  assign bus.runs_done_o = runs_done_q;
  assign bus.cycles_o    = cycles_q;

endmodule

// File: tb/tb_mm_run_sequencer.sv
// Bench for mm_run_sequencer: three instances (default, short watchdog, 4-bit cycle counter).
module tb_mm_run_sequencer;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  mm_run_sequencer_if #(.RUN_WIDTH(16), .CYCLE_WIDTH(32)) ifA ();
  mm_run_sequencer_if #(.RUN_WIDTH(16), .CYCLE_WIDTH(32)) ifB ();
  mm_run_sequencer_if #(.RUN_WIDTH(16), .CYCLE_WIDTH(4))  ifC ();

  mm_run_sequencer #(.RUN_WIDTH(16), .CYCLE_WIDTH(32), .TIMEOUT(4096)) dutA (
    .clock_i(clock), .reset_i(reset_n), .bus(ifA.slave));
  mm_run_sequencer #(.RUN_WIDTH(16), .CYCLE_WIDTH(32), .TIMEOUT(16)) dutB (
    .clock_i(clock), .reset_i(reset_n), .bus(ifB.slave));
  mm_run_sequencer #(.RUN_WIDTH(16), .CYCLE_WIDTH(4), .TIMEOUT(0)) dutC (
    .clock_i(clock), .reset_i(reset_n), .bus(ifC.slave));

  typedef struct {
    int runs;
    int lat;
    int abort_run;
    int exp_starts;
    int exp_runs_done;
    int exp_cycles;
    int exp_done;
  } vec_t;

  vec_t vecs[5];
  vec_t sbq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Core model for instance A: done pulse lat cycles after start, optional abort on done #abort_run.
  int latA = 1, cntA = 0, abort_runA = 0, doneCntA = 0;
  initial begin
    ifA.mm_done_i = 1'b0;
    ifA.abort_i   = 1'b0;
    forever begin
      @(negedge clock);
      ifA.mm_done_i = 1'b0;
      ifA.abort_i   = 1'b0;
      if (!reset_n) cntA = 0;
      else if (ifA.mm_start_o) cntA = latA;
      else if (cntA != 0) begin
        cntA--;
        if (cntA == 0) begin
          ifA.mm_done_i = 1'b1;
          doneCntA++;
          if (doneCntA == abort_runA) ifA.abort_i = 1'b1;
        end
      end
    end
  end

  task automatic run_vec(input vec_t v, input string tag);
    int starts, dones, last_start, last_mmdone, done_cyc, spacing_bad;
    bit timed_out;
    vec_t e;
    @(negedge clock); #1;
    latA = v.lat; abort_runA = v.abort_run; doneCntA = 0;
    ifA.cmd_runs_i  = 16'(v.runs);
    ifA.cmd_valid_i = 1'b1;
    sbq.push_back(v);
    @(negedge clock); #1;
    ifA.cmd_valid_i = 1'b0;
    starts = 0; dones = 0; last_start = -1; last_mmdone = -1; done_cyc = -1;
    spacing_bad = 0; timed_out = 1'b1;
    for (int c = 1; c < 2000; c++) begin
      if (ifA.mm_start_o) begin
        if (last_start >= 0 && (c - last_start) != v.lat + 2) spacing_bad++;
        last_start = c;
        starts++;
      end
      if (ifA.mm_done_i) last_mmdone = c;
      if (ifA.done_o) begin dones++; done_cyc = c; end
      if (ifA.cmd_ready_o) begin timed_out = 1'b0; break; end
      @(negedge clock); #1;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clock); #1;
      if (ifA.mm_start_o) starts++;
    end
    e = sbq.pop_front();
    check({tag, " batch_end_timeout"}, 64'(timed_out), 0);
    check({tag, " starts"}, 64'(starts), 64'(e.exp_starts));
    check({tag, " runs_done"}, 64'(ifA.runs_done_o), 64'(e.exp_runs_done));
    check({tag, " cycles"}, 64'(ifA.cycles_o), 64'(e.exp_cycles));
    check({tag, " done_pulses"}, 64'(dones), 64'(e.exp_done));
    check({tag, " error"}, 64'(ifA.error_o), 0);
    check({tag, " start_spacing_bad"}, 64'(spacing_bad), 0);
    if (e.exp_done != 0) begin
      if (e.runs == 0) check({tag, " done_at_k+1"}, 64'(done_cyc), 1);
      else check({tag, " done_after_last_mmdone"}, 64'(done_cyc - last_mmdone), 1);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int sB, eB, dn, due, dC;
    ifA.cmd_valid_i = 1'b0; ifA.cmd_runs_i = '0;
    ifB.cmd_valid_i = 1'b0; ifB.cmd_runs_i = '0; ifB.abort_i = 1'b0; ifB.mm_done_i = 1'b0;
    ifC.cmd_valid_i = 1'b0; ifC.cmd_runs_i = '0; ifC.abort_i = 1'b0; ifC.mm_done_i = 1'b0;

    //            runs lat abort starts rdone cycles done
    vecs[0] = '{3,   50, 0,    3,     3,    155,   1};
    vecs[1] = '{0,   50, 0,    0,     0,    0,     1};
    vecs[2] = '{5,   10, 2,    2,     1,    23,    0};
    vecs[3] = '{1,   1,  0,    1,     1,    2,     1};
    vecs[4] = '{2,   3,  0,    2,     2,    9,     1};

    #1;
    check("reset mm_start", 64'(ifA.mm_start_o), 0);
    check("reset busy", 64'(ifA.busy_o), 0);
    check("reset done", 64'(ifA.done_o), 0);
    check("reset error", 64'(ifA.error_o), 0);
    check("reset runs_done", 64'(ifA.runs_done_o), 0);
    check("reset cycles", 64'(ifA.cycles_o), 0);
    repeat (3) @(negedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock); #1;
    check("post-reset ready", 64'(ifA.cmd_ready_o), 1);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Watchdog expiry on B: start at cycle 1, ERROR entered after 16 WAIT cycles.
    @(negedge clock); #1;
    ifB.cmd_runs_i = 16'd2; ifB.cmd_valid_i = 1'b1;
    @(negedge clock); #1;
    ifB.cmd_valid_i = 1'b0;
    sB = -1; eB = -1; dn = 0;
    for (int c = 1; c < 100; c++) begin
      if (ifB.mm_start_o) sB = c;
      if (ifB.done_o) dn++;
      if (ifB.error_o) begin eB = c; break; end
      @(negedge clock); #1;
    end
    check("wdog start_to_error", 64'(eB - sB), 17);
    check("wdog cycles", 64'(ifB.cycles_o), 17);
    check("wdog runs_done", 64'(ifB.runs_done_o), 0);
    check("wdog no_done", 64'(dn), 0);
    @(negedge clock); #1;
    check("wdog ready_after", 64'(ifB.cmd_ready_o), 1);
    check("wdog error_sticky", 64'(ifB.error_o), 1);
    check("wdog no_start_after", 64'(ifB.mm_start_o), 0);
    ifB.cmd_runs_i = 16'd0; ifB.cmd_valid_i = 1'b1;
    @(negedge clock); #1;
    ifB.cmd_valid_i = 1'b0;
    check("wdog error_cleared", 64'(ifB.error_o), 0);
    check("wdog zero_runs_done", 64'(ifB.done_o), 1);

    // Done on the very cycle the watchdog would expire: completion wins.
    @(negedge clock); #1;
    ifB.cmd_runs_i = 16'd1; ifB.cmd_valid_i = 1'b1;
    @(negedge clock); #1;
    ifB.cmd_valid_i = 1'b0;
    repeat (16) begin @(negedge clock); #1; end
    ifB.mm_done_i = 1'b1;
    @(negedge clock); #1;
    ifB.mm_done_i = 1'b0;
    check("race done_o", 64'(ifB.done_o), 1);
    check("race error", 64'(ifB.error_o), 0);
    check("race runs_done", 64'(ifB.runs_done_o), 1);
    check("race cycles", 64'(ifB.cycles_o), 17);

    // C: 4-bit cycle counter saturates; extra done pulses in GAP/DONE/IDLE are ignored.
    @(negedge clock); #1;
    ifC.cmd_runs_i = 16'd2; ifC.cmd_valid_i = 1'b1;
    @(negedge clock); #1;
    ifC.cmd_valid_i = 1'b0;
    due = -100; dC = 0;
    for (int c = 1; c < 200; c++) begin
      if (ifC.cmd_ready_o) break;
      if (c == 10) check("sat cycles_pre", 64'(ifC.cycles_o), 9);
      if (ifC.done_o) dC++;
      if (ifC.mm_start_o) due = c + 20;
      ifC.mm_done_i = (c == due) || (c == due + 1);
      @(negedge clock); #1;
    end
    ifC.mm_done_i = 1'b0;
    check("sat cycles", 64'(ifC.cycles_o), 15);
    check("sat runs_done", 64'(ifC.runs_done_o), 2);
    check("sat done_pulses", 64'(dC), 1);
    check("sat error", 64'(ifC.error_o), 0);
    ifC.mm_done_i = 1'b1;
    @(negedge clock); #1;
    ifC.mm_done_i = 1'b0;
    @(negedge clock); #1;
    check("idle spurious runs_done", 64'(ifC.runs_done_o), 2);
    check("idle spurious busy", 64'(ifC.busy_o), 0);

    // Asynchronous reset mid-WAIT on A, then a normal batch.
    @(negedge clock); #1;
    latA = 50; abort_runA = 0; doneCntA = 0;
    ifA.cmd_runs_i = 16'd3; ifA.cmd_valid_i = 1'b1;
    @(negedge clock); #1;
    ifA.cmd_valid_i = 1'b0;
    repeat (10) begin @(negedge clock); #1; end
    check("pre-reset busy", 64'(ifA.busy_o), 1);
    #2 reset_n = 1'b0;
    #1;
    check("async busy", 64'(ifA.busy_o), 0);
    check("async cycles", 64'(ifA.cycles_o), 0);
    check("async mm_start", 64'(ifA.mm_start_o), 0);
    check("async error", 64'(ifA.error_o), 0);
    @(negedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock); #1;
    check("async ready_after", 64'(ifA.cmd_ready_o), 1);
    run_vec(vecs[4], "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
